// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, function codes and ID/EX state type
//
// Widths of the decoded-instruction fields, the ID/EX register state
// encoding, the function codes this stage must recognise, and a helper
// that flags the multi-cycle multiply/divide operations.

package pipe_pkg;

    localparam int W_OPER = 6;
    localparam int W_FUNC = 6;
    localparam int W_DATA = 32;
    localparam int W_REGN = 5;

    typedef enum logic [1:0] {
        BUBBLE = 2'd0,
        LIVE   = 2'd1,
        MDWAIT = 2'd2,
        MDKILL = 2'd3
    } idex_state_t;

    localparam logic [W_FUNC-1:0] FUNC_NOP   = 6'h00;
    localparam logic [W_FUNC-1:0] FUNC_MULT  = 6'h18;
    localparam logic [W_FUNC-1:0] FUNC_MULTU = 6'h19;
    localparam logic [W_FUNC-1:0] FUNC_DIV   = 6'h1a;
    localparam logic [W_FUNC-1:0] FUNC_DIVU  = 6'h1b;
    localparam logic [W_FUNC-1:0] FUNC_ADD   = 6'h20;

    // Operations that run inside mulalu for more than one cycle.
    function automatic logic is_muldiv(input logic [W_FUNC-1:0] func);
        return (func == FUNC_MULT) || (func == FUNC_MULTU) ||
               (func == FUNC_DIV)  || (func == FUNC_DIVU);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - three-way operand source select (MEM, WB, register file)
//
// Ports:
//   src              source register number being read
//   rf_data          register-file read value for src
//   mem_wreg/dst/data  result in flight in MEM
//   wb_wreg/dst/data   result in flight in WB
//   data             selected operand value
// MEM is younger than WB, so it takes priority. Register 0 is hard-wired
// and is never forwarded.

module fwd_mux
    import pipe_pkg::*;
(
    input  logic [W_REGN-1:0] src,
    input  logic [W_DATA-1:0] rf_data,
    input  logic              mem_wreg,
    input  logic [W_REGN-1:0] mem_dst,
    input  logic [W_DATA-1:0] mem_data,
    input  logic              wb_wreg,
    input  logic [W_REGN-1:0] wb_dst,
    input  logic [W_DATA-1:0] wb_data,
    output logic [W_DATA-1:0] data
);

    always_comb begin
        data = rf_data;
        if (src != '0) begin
            if (mem_wreg && (mem_dst == src)) begin
                data = mem_data;
            end else if (wb_wreg && (wb_dst == src)) begin
                data = wb_data;
            end
        end
    end

endmodule

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID to EX pipeline register with forwarding and mul/div hold
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   id_*                        decoded instruction and register-file reads
//   mem_*/wb_*                  forwarding sources
//   flush                       kill younger instructions
//   alu_stall, mem_stall        mulalu busy, EX/MEM register full
//   id_stall, reg_stall         hold requests to ID and to mulalu
//   ex_*                        registered instruction presented to EX
// A busy multiply/divide keeps its operands frozen; a flush arriving while
// it is busy only drops ex_valid (MDKILL) so mulalu still sees a clean end.

module idex_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [W_OPER-1:0] id_oper,
    input  logic [W_FUNC-1:0] id_func,
    input  logic [W_REGN-1:0] id_rs,
    input  logic [W_REGN-1:0] id_rt,
    input  logic [W_DATA-1:0] id_rs_data,
    input  logic [W_DATA-1:0] id_rt_data,
    input  logic [W_REGN-1:0] id_dst,
    input  logic              id_wreg,
    input  logic              mem_wreg,
    input  logic [W_REGN-1:0] mem_dst,
    input  logic [W_DATA-1:0] mem_data,
    input  logic              wb_wreg,
    input  logic [W_REGN-1:0] wb_dst,
    input  logic [W_DATA-1:0] wb_data,
    input  logic              flush,
    input  logic              alu_stall,
    input  logic              mem_stall,
    output logic              id_stall,
    output logic              reg_stall,
    output logic              ex_valid,
    output logic [W_OPER-1:0] ex_oper,
    output logic [W_FUNC-1:0] ex_func,
    output logic [W_DATA-1:0] ex_source_a,
    output logic [W_DATA-1:0] ex_source_b,
    output logic [W_REGN-1:0] ex_dst,
    output logic              ex_wreg
);

    idex_state_t       state;
    logic              hold;
    logic              wreg_q;
    logic [W_DATA-1:0] fwd_a;
    logic [W_DATA-1:0] fwd_b;

    assign hold      = alu_stall | mem_stall;
    assign id_stall  = hold;
    assign reg_stall = mem_stall;

    fwd_mux u_fwd_rs (
        .src      (id_rs),
        .rf_data  (id_rs_data),
        .mem_wreg (mem_wreg),
        .mem_dst  (mem_dst),
        .mem_data (mem_data),
        .wb_wreg  (wb_wreg),
        .wb_dst   (wb_dst),
        .wb_data  (wb_data),
        .data     (fwd_a)
    );

    fwd_mux u_fwd_rt (
        .src      (id_rt),
        .rf_data  (id_rt_data),
        .mem_wreg (mem_wreg),
        .mem_dst  (mem_dst),
        .mem_data (mem_data),
        .wb_wreg  (wb_wreg),
        .wb_dst   (wb_dst),
        .wb_data  (wb_data),
        .data     (fwd_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BUBBLE;
            ex_oper     <= '0;
            ex_func     <= FUNC_NOP;
            ex_source_a <= '0;
            ex_source_b <= '0;
            ex_dst      <= '0;
            wreg_q      <= 1'b0;
        end else if (!hold) begin
            // Free-running load; the slot becomes a bubble if ID is empty
            // or the instruction is being flushed.
            ex_oper     <= id_oper;
            ex_source_a <= fwd_a;
            ex_source_b <= fwd_b;
            ex_dst      <= id_dst;
            wreg_q      <= id_wreg;
            if (flush || !id_valid) begin
                state   <= BUBBLE;
                ex_func <= FUNC_NOP;
            end else begin
                state   <= LIVE;
                ex_func <= id_func;
            end
        end else begin
            case (state)
                LIVE: begin
                    if (is_muldiv(ex_func) && alu_stall) begin
                        // mulalu has started: keep func/operands, defer any flush.
                        state <= flush ? MDKILL : MDWAIT;
                    end else if (flush) begin
                        state   <= BUBBLE;
                        ex_func <= FUNC_NOP;
                    end
                end
                MDWAIT: begin
                    if (flush) begin
                        state <= MDKILL;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ex_valid = (state == LIVE) || (state == MDWAIT);
    assign ex_wreg  = wreg_q & ex_valid;

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - self-checking bench for idex_stage

module tb_idex_stage;
    import pipe_pkg::*;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [W_OPER-1:0] id_oper;
    logic [W_FUNC-1:0] id_func;
    logic [W_REGN-1:0] id_rs;
    logic [W_REGN-1:0] id_rt;
    logic [W_DATA-1:0] id_rs_data;
    logic [W_DATA-1:0] id_rt_data;
    logic [W_REGN-1:0] id_dst;
    logic              id_wreg;
    logic              mem_wreg;
    logic [W_REGN-1:0] mem_dst;
    logic [W_DATA-1:0] mem_data;
    logic              wb_wreg;
    logic [W_REGN-1:0] wb_dst;
    logic [W_DATA-1:0] wb_data;
    logic              flush;
    logic              alu_stall;
    logic              mem_stall;
    logic              id_stall;
    logic              reg_stall;
    logic              ex_valid;
    logic [W_OPER-1:0] ex_oper;
    logic [W_FUNC-1:0] ex_func;
    logic [W_DATA-1:0] ex_source_a;
    logic [W_DATA-1:0] ex_source_b;
    logic [W_REGN-1:0] ex_dst;
    logic              ex_wreg;

    int checks   = 0;
    int failures = 0;

    // Reference: what EX holds, whether it is live, and whether a busy
    // multiply/divide has frozen the slot.
    logic              m_valid;
    logic              m_locked;
    logic [W_OPER-1:0] m_oper;
    logic [W_FUNC-1:0] m_func;
    logic [W_DATA-1:0] m_a;
    logic [W_DATA-1:0] m_b;
    logic [W_REGN-1:0] m_dst;
    logic              m_wreg;

    idex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_oper(id_oper), .id_func(id_func),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_dst(id_dst), .id_wreg(id_wreg), .mem_wreg(mem_wreg), .mem_dst(mem_dst),
        .mem_data(mem_data), .wb_wreg(wb_wreg), .wb_dst(wb_dst), .wb_data(wb_data),
        .flush(flush), .alu_stall(alu_stall), .mem_stall(mem_stall), .id_stall(id_stall),
        .reg_stall(reg_stall), .ex_valid(ex_valid), .ex_oper(ex_oper), .ex_func(ex_func),
        .ex_source_a(ex_source_a), .ex_source_b(ex_source_b), .ex_dst(ex_dst), .ex_wreg(ex_wreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W_DATA-1:0] pick(input logic [W_REGN-1:0] src,
                                               input logic [W_DATA-1:0] rf);
        if (src != 0 && mem_wreg && mem_dst == src) return mem_data;
        if (src != 0 && wb_wreg && wb_dst == src) return wb_data;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_locked = 0; m_oper = 0; m_func = FUNC_NOP;
        m_a = 0; m_b = 0; m_dst = 0; m_wreg = 0;
    endtask

    task automatic model_update();
        if (!(alu_stall || mem_stall)) begin
            m_oper = id_oper; m_a = pick(id_rs, id_rs_data); m_b = pick(id_rt, id_rt_data);
            m_dst = id_dst; m_wreg = id_wreg; m_locked = 0;
            m_valid = id_valid && !flush;
            m_func = m_valid ? id_func : FUNC_NOP;
        end else if (m_locked) begin
            if (flush) m_valid = 0;
        end else if (m_valid && is_muldiv(m_func) && alu_stall) begin
            m_locked = 1;
            if (flush) m_valid = 0;
        end else if (flush) begin
            m_valid = 0; m_func = FUNC_NOP;
        end
    endtask

    task automatic compare_all();
        check_eq("ex_valid", ex_valid, m_valid);
        check_eq("ex_func", ex_func, m_func);
        check_eq("ex_oper", ex_oper, m_oper);
        check_eq("ex_source_a", ex_source_a, m_a);
        check_eq("ex_source_b", ex_source_b, m_b);
        check_eq("ex_dst", ex_dst, m_dst);
        check_eq("ex_wreg", ex_wreg, m_valid & m_wreg);
        check_eq("id_stall", id_stall, alu_stall | mem_stall);
        check_eq("reg_stall", reg_stall, mem_stall);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_idle();
        id_valid = 0; id_oper = 0; id_func = FUNC_NOP; id_rs = 0; id_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_dst = 0; id_wreg = 0;
        mem_wreg = 0; mem_dst = 0; mem_data = 0; wb_wreg = 0; wb_dst = 0; wb_data = 0;
        flush = 0; alu_stall = 0; mem_stall = 0;
    endtask

    task automatic set_instr(input logic [W_FUNC-1:0] f, input logic [W_DATA-1:0] a,
                             input logic [W_DATA-1:0] b, input logic [W_REGN-1:0] d);
        id_valid = 1; id_oper = 6'h01; id_func = f; id_rs = 5'd1; id_rt = 5'd2;
        id_rs_data = a; id_rt_data = b; id_dst = d; id_wreg = 1;
    endtask

    initial begin
        rst = 0;
        set_idle();
        model_reset();
        #12;
        compare_all();
        check_eq("rst_func_nop", ex_func, FUNC_NOP);
        @(negedge clk);
        rst = 1;

        // Forwarding priority and register 0.
        set_instr(FUNC_ADD, 32'h99, 32'h5, 5'd4);
        id_rs = 5'd3; mem_wreg = 1; mem_dst = 5'd3; mem_data = 32'h11;
        wb_wreg = 1; wb_dst = 5'd3; wb_data = 32'h22;
        step();
        check_eq("fwd_mem_first", ex_source_a, 32'h11);
        mem_wreg = 0;
        step();
        check_eq("fwd_wb", ex_source_a, 32'h22);
        id_rs = 0; mem_wreg = 1; mem_dst = 0; wb_dst = 0; id_rs_data = 32'hABCD;
        step();
        check_eq("fwd_r0_never", ex_source_a, 32'hABCD);

        // MULT busy for 5 cycles, next instruction waits in ID.
        set_idle();
        set_instr(FUNC_MULT, 32'h7, 32'h9, 5'd5);
        step();
        set_instr(FUNC_ADD, 32'h100, 32'h200, 5'd6);
        alu_stall = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("mult_func_held", ex_func, FUNC_MULT);
            check_eq("mult_a_held", ex_source_a, 32'h7);
        end
        alu_stall = 0;
        step();
        check_eq("mult_next_instr", ex_func, FUNC_ADD);

        // DIV busy, flush pulse mid-way: invalid but still DIV until done.
        set_idle();
        set_instr(FUNC_DIV, 32'h40, 32'h8, 5'd7);
        step();
        alu_stall = 1;
        step();
        step();
        flush = 1;
        step();
        flush = 0;
        step();
        check_eq("divkill_valid", ex_valid, 1'b0);
        check_eq("divkill_func", ex_func, FUNC_DIV);
        alu_stall = 0; id_valid = 0;
        step();
        check_eq("divkill_bubble", ex_func, FUNC_NOP);

        // MUL finishes while mem_stall holds EX for 2 cycles.
        set_instr(FUNC_MULT, 32'h3, 32'h4, 5'd8);
        step();
        alu_stall = 1;
        step();
        set_instr(FUNC_ADD, 32'h1, 32'h2, 5'd9);
        alu_stall = 0; mem_stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("mulmem_reg_stall", reg_stall, 1'b1);
            check_eq("mulmem_func", ex_func, FUNC_MULT);
        end
        mem_stall = 0;
        step();
        check_eq("mulmem_advance", ex_func, FUNC_ADD);

        // LIVE ADD with mem_stall and flush together.
        mem_stall = 1; flush = 1;
        step();
        check_eq("add_flush_hold", ex_valid, 1'b0);
        set_idle();

        // Asynchronous reset in the middle of a DIV.
        set_instr(FUNC_DIV, 32'h55, 32'h5, 5'd10);
        step();
        alu_stall = 1;
        step();
        #2;
        rst = 0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_mid_div_func", ex_func, FUNC_NOP);
        @(negedge clk);
        rst = 1;
        set_idle();
        step();
        check_eq("post_rst_bubble", ex_valid, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            id_valid = ($urandom_range(0, 9) < 8);
            id_oper = 6'($urandom);
            case ($urandom_range(0, 3))
                0: id_func = FUNC_ADD;
                1: id_func = FUNC_MULT;
                2: id_func = FUNC_DIV;
                default: id_func = 6'($urandom);
            endcase
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_rs_data = $urandom; id_rt_data = $urandom;
            id_dst = 5'($urandom); id_wreg = 1'($urandom);
            mem_wreg = 1'($urandom); mem_dst = 5'($urandom_range(0, 3)); mem_data = $urandom;
            wb_wreg = 1'($urandom); wb_dst = 5'($urandom_range(0, 3)); wb_data = $urandom;
            flush = ($urandom_range(0, 99) < 8);
            mem_stall = ($urandom_range(0, 99) < 15);
            if (m_locked || (m_valid && is_muldiv(m_func)))
                alu_stall = ($urandom_range(0, 99) < 70);
            else
                alu_stall = ($urandom_range(0, 99) < 10);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
